// File: rtl/sky_timing_gen.sv
// sky_timing_gen: raster timing source for the night-sky scene.
// Produces pixel coordinates, sync/blanking strobes, per-line and per-frame
// pulses, a completed-frame counter and a slow sawtooth fade level.
//
// Ports:
//   clk_pix      in   pixel clock, all state changes on its rising edge
//   rst          in   asynchronous active-high reset
//   freeze       in   holds fade_level and its divider (sampled at frame wrap)
//   sx, sy       out  raster position (10 bits each)
//   hsync, vsync out  active-low sync strobes
//   de           out  high inside the visible area
//   line         out  one-cycle pulse at sx==0 (every line)
//   frame        out  one-cycle pulse at sx==0, sy==0
//   frame_count  out  completed-frame counter, wraps at 16 bits
//   fade_level   out  sawtooth fade value, steps every FADE_DIV frames
module sky_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int FADE_DIV = 4
) (
    input  logic        clk_pix,
    input  logic        rst,
    input  logic        freeze,
    output logic [9:0]  sx,
    output logic [9:0]  sy,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        line,
    output logic        frame,
    output logic [15:0] frame_count,
    output logic [7:0]  fade_level
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    localparam int DIV_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FADE_DIV - 1);

    logic [9:0]       sx_next;
    logic [9:0]       sy_next;
    logic             h_wrap;
    logic             frame_wrap;
    logic [DIV_W-1:0] div_cnt;

    // Next raster position; strobes are registered from these so they line
    // up with the coordinates presented in the same cycle.
    always_comb begin
        sx_next    = sx + 10'd1;
        sy_next    = sy;
        h_wrap     = (sx == H_LAST);
        frame_wrap = h_wrap && (sy == V_LAST);
        if (h_wrap) begin
            sx_next = '0;
            sy_next = (sy == V_LAST) ? '0 : sy + 10'd1;
        end
    end

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            sx          <= '0;
            sy          <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b1;
            line        <= 1'b0;
            frame       <= 1'b0;
            frame_count <= '0;
            fade_level  <= '0;
            div_cnt     <= '0;
        end else begin
            sx    <= sx_next;
            sy    <= sy_next;
            hsync <= !((sx_next >= HS_START) && (sx_next < HS_END));
            vsync <= !((sy_next >= VS_START) && (sy_next < VS_END));
            de    <= (sx_next < H_ACT) && (sy_next < V_ACT);
            line  <= h_wrap;
            frame <= frame_wrap;
            if (frame_wrap) begin
                frame_count <= frame_count + 16'd1;
                // freeze only matters here: it holds both fade state registers
                if (!freeze) begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt    <= '0;
                        fade_level <= fade_level + 8'd1;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: doc/sky_timing_gen.md
# sky_timing_gen

Raster timing source for the night-sky scene. It generates the pixel coordinates (sx, sy), sync/blanking strobes and the per-line and per-frame pulses that the scene renderers consume. It also generates the 16-bit frame counter and 8-bit fade level that drive star blinking and day/night fading. It sits at the root of the video pipeline, clocked by the pixel clock, and feeds every renderer and the VGA output register stage.

## Interface

Parameters (defaults are 640x480 @ 60 Hz, 25.175 MHz pixel clock):
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, horizontal sync width (cycles)
- H_BP, 48, horizontal back porch (cycles)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- FADE_DIV, 4, frames per fade_level step (must be at least 1)

Ports:
- clk_pix  in  1  pixel clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- freeze  in  1  when high, fade_level and the fade divider hold; raster and frame_count keep running
- sx  out  10  horizontal position, 0 to H_TOTAL-1
- sy  out  10  vertical position, 0 to V_TOTAL-1; consumers with 9-bit sy take sy[8:0] and must gate with de
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- de  out  1  high when sx < H_ACTIVE and sy < V_ACTIVE
- line  out  1  one-cycle pulse at sx==0, on every line including blanking lines
- frame  out  1  one-cycle pulse at sx==0 and sy==0
- frame_count  out  16  completed-frame counter, wraps 65535 to 0
- fade_level  out  8  sawtooth fade value, wraps 255 to 0

## Operation

- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- sx increments every cycle. At H_TOTAL-1 it wraps to 0 and sy increments. sy wraps to 0 after V_TOTAL-1.
- The frame wrap is the cycle in which (sx,sy) goes from (H_TOTAL-1, V_TOTAL-1) to (0,0).
- hsync is low iff H_ACTIVE+H_FP ≤ sx < H_ACTIVE+H_FP+H_SYNC (656..751).
- vsync is low iff V_ACTIVE+V_FP ≤ sy < V_ACTIVE+V_FP+V_SYNC (490..491), for whole lines, sx 0..799.
- Fade divider (div_cnt, range 0..FADE_DIV-1), updated only at a frame wrap with freeze low:
  - if div_cnt == FADE_DIV-1: div_cnt becomes 0 and fade_level increments by 1 (mod 256);
  - otherwise div_cnt increments.
- A frame wrap with freeze high leaves div_cnt and fade_level unchanged.
- frame_count increments by 1 (mod 65536) at every frame wrap, regardless of freeze.
- Reset values: sx=0, sy=0, hsync=1, vsync=1, de=1, line=0, frame=0, frame_count=0, fade_level=0, div_cnt=0.
- The (0,0) position held during and immediately after reset produces no line or frame pulse. The first line pulse comes at the first sx wrap; the first frame pulse comes at the first frame wrap.

## Timing

- All outputs are registers. Sync, de, line and frame are computed from the next-cycle counter values, so every output is consistent with the sx/sy presented in the same cycle. There is no pipeline skew between coordinates and strobes.
- frame_count and fade_level take their new values in the same cycle that frame is high (sx=0, sy=0).
- freeze is sampled only at the frame-wrap edge. Toggling it elsewhere has no effect.
- Asserting rst forces all outputs to their reset values immediately, with no clock edge required, including mid-line or mid-frame. Counting resumes from (0,0) on the first clk_pix edge after rst deasserts; that edge produces sx=1.
- Frame period is H_TOTAL*V_TOTAL = 420000 cycles. The line period is 800 cycles.

## Test plan

- Reset release: sx steps 0,1,2,… each cycle. 799 cycles after release sx=0 and sy=1, with line=1 for exactly that one cycle and frame=0.
- Horizontal strobes on one line: hsync low for exactly 96 cycles (sx 656..751); de high for sx 0..639 and low for 640..799 on sy<480; de low for the whole of sy 480..524.
- Vertical/frame: vsync low exactly at sy 490..491 (1600 cycles). First frame pulse occurs 419999 cycles after release at (0,0), with frame_count=1. The next frame pulse follows 420000 cycles later with frame_count=2.
- Fade with FADE_DIV=2 and small raster override (H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1): fade_level stays 0 through the first wrap, becomes 1 at the 2nd wrap and 2 at the 4th. After 512 wraps it returns to 0. frame_count equals the number of wraps.
- freeze held high across 3 frame wraps (small raster): fade_level and div_cnt unchanged, frame_count +3. Releasing freeze resumes stepping from the held div_cnt.
- Asynchronous reset mid-frame at sx=300, sy=200 asserted between clock edges: all outputs at reset values before the next edge, including frame_count=0 and fade_level=0. After release the sequence restarts exactly as in the first scenario.
